// File: rtl/mul_req_arbiter_if.sv
// Handshake and core-side bundle for the two-requester multiplier arbiter.
// The master view belongs to the arbiter, the slave view to its environment.
interface mul_req_arbiter_if #(
    parameter int A_W = 24,
    parameter int P_W = 48
);
    logic           req0_valid;
    logic           req0_ready;
    logic [31:0]    req0_a;
    logic [31:0]    req0_b;
    logic           req1_valid;
    logic           req1_ready;
    logic [31:0]    req1_a;
    logic [31:0]    req1_b;

    logic           rsp0_valid;
    logic           rsp0_ready;
    logic [31:0]    rsp0_result;
    logic           rsp0_ovf;
    logic           rsp0_err;
    logic           rsp1_valid;
    logic           rsp1_ready;
    logic [31:0]    rsp1_result;
    logic           rsp1_ovf;
    logic           rsp1_err;

    logic           mul_start;
    logic [A_W-1:0] mul_a;
    logic [A_W-1:0] mul_b;
    logic           mul_done;
    logic [P_W-1:0] mul_product;

    modport master (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp0_valid, rsp0_result, rsp0_ovf, rsp0_err,
        input  rsp0_ready,
        output rsp1_valid, rsp1_result, rsp1_ovf, rsp1_err,
        input  rsp1_ready,
        output mul_start, mul_a, mul_b,
        input  mul_done, mul_product
    );

    modport slave (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_ovf, rsp0_err,
        output rsp0_ready,
        input  rsp1_valid, rsp1_result, rsp1_ovf, rsp1_err,
        output rsp1_ready,
        input  mul_start, mul_a, mul_b,
        output mul_done, mul_product
    );
endinterface

// File: rtl/mul_req_arbiter.sv
// Round-robin sharing of one sequential multiplier core between two requesters.
// Range-checks operands, sequences start/done, times out a stuck core.
module mul_req_arbiter #(
    parameter int A_W     = 24,
    parameter int P_W     = 48,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              n_reset,
    mul_req_arbiter_if.master bus,
    output logic [31:0]       done_count,
    output logic              busy,
    output logic              last_grant
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic           owner_q;
    logic           prio_q;
    logic           lg_q;
    logic [A_W-1:0] a_q;
    logic [A_W-1:0] b_q;
    logic [31:0]    res_q;
    logic           ovf_q;
    logic           err_q;
    logic [31:0]    cnt_q;
    logic [TW-1:0]  tcnt_q;

    logic           gnt0;
    logic           gnt1;
    logic           accept;
    logic           acc_idx;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           range_bad;
    logic           timeout_hit;
    logic           rsp_hs;
    logic           start;

    // Arbitration: only in IDLE; on contention favour the one not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = prio_q;
                gnt1 = ~prio_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign accept  = gnt0 | gnt1;
    assign acc_idx = gnt1;

    assign sel_a = gnt1 ? bus.req1_a : bus.req0_a;
    assign sel_b = gnt1 ? bus.req1_b : bus.req0_b;

    assign range_bad = (|sel_a[31:A_W]) | (|sel_b[31:A_W]);

    assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));

    assign rsp_hs = (state_q == RESP) &&
                    (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and core start pulse.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = range_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                start   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mul_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant history: prio_q steers contention, lg_q is the visible index.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            owner_q <= 1'b0;
            prio_q  <= 1'b1;
            lg_q    <= 1'b0;
        end else if (accept) begin
            owner_q <= acc_idx;
            prio_q  <= acc_idx;
            lg_q    <= acc_idx;
        end
    end

    // Operand latch; held through ISSUE and WAIT for the core.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= sel_a[A_W-1:0];
            b_q <= sel_b[A_W-1:0];
        end
    end

    // Cycles spent in WAIT since the start pulse.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tcnt_q <= '0;
        end else if (state_q == ISSUE) begin
            tcnt_q <= '0;
        end else if (state_q == WAIT && !timeout_hit) begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    // Response capture: range error at accept, product or timeout in WAIT.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else if (accept && range_bad) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b1;
        end else if (state_q == WAIT) begin
            if (bus.mul_done) begin
                res_q <= bus.mul_product[31:0];
                ovf_q <= |bus.mul_product[P_W-1:32];
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                res_q <= '0;
                ovf_q <= 1'b0;
                err_q <= 1'b1;
            end
        end
    end

    // Successful completions; a late or stray done outside WAIT is ignored.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else if (state_q == WAIT && bus.mul_done) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    assign bus.rsp0_valid  = (state_q == RESP) && !owner_q;
    assign bus.rsp1_valid  = (state_q == RESP) &&  owner_q;

    assign bus.rsp0_result = bus.rsp0_valid ? res_q : '0;
    assign bus.rsp0_ovf    = bus.rsp0_valid & ovf_q;
    assign bus.rsp0_err    = bus.rsp0_valid & err_q;
    assign bus.rsp1_result = bus.rsp1_valid ? res_q : '0;
    assign bus.rsp1_ovf    = bus.rsp1_valid & ovf_q;
    assign bus.rsp1_err    = bus.rsp1_valid & err_q;

    assign bus.mul_start = start;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;

    assign done_count = cnt_q;
    assign busy       = (state_q != IDLE);
    assign last_grant = lg_q;

endmodule

// File: tb/tb_mul_req_arbiter.sv
// Scoreboard bench for mul_req_arbiter with a behavioural multiplier core.
// Stimulus pushes hand-computed responses; a monitor pops them on handshake.
module tb_mul_req_arbiter;

    localparam int A_W     = 24;
    localparam int P_W     = 48;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        n_reset;
    logic [31:0] done_count;
    logic        busy;
    logic        last_grant;

    mul_req_arbiter_if #(.A_W(A_W), .P_W(P_W)) ifc ();

    mul_req_arbiter #(
        .A_W     (A_W),
        .P_W     (P_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .bus        (ifc),
        .done_count (done_count),
        .busy       (busy),
        .last_grant (last_grant)
    );

    typedef struct {
        bit          idx;
        logic [31:0] res;
        bit          ovf;
        bit          err;
    } exp_t;

    exp_t q[$];
    bit   grants[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int starts      = 0;
    int start_cyc   = 0;
    int rise0       = 0;
    int rise1       = 0;
    int core_k      = 4;
    bit stray       = 0;
    bit p0          = 0;
    bit p1          = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Behavioural core: done k cycles after start, or a requested stray pulse.
    initial begin
        ifc.mul_done    = 1'b0;
        ifc.mul_product = '0;
        forever begin
            @(negedge clk);
            if (ifc.mul_start) begin
                starts++;
                start_cyc = cyc;
                if (core_k > 0) begin
                    repeat (core_k) @(posedge clk);
                    #1;
                    ifc.mul_done    = 1'b1;
                    ifc.mul_product = 48'(ifc.mul_a) * 48'(ifc.mul_b);
                    @(posedge clk);
                    #1;
                    ifc.mul_done = 1'b0;
                end
            end else if (stray) begin
                stray           = 1'b0;
                ifc.mul_done    = 1'b1;
                ifc.mul_product = 48'h51;
                @(posedge clk);
                #1;
                ifc.mul_done = 1'b0;
            end
        end
    end

    // Monitor: rise times, grant order, response scoreboard.
    always @(negedge clk) begin
        if (n_reset) begin
            if (ifc.rsp0_valid && !p0) rise0 = cyc;
            if (ifc.rsp1_valid && !p1) rise1 = cyc;
            if (ifc.req0_valid && ifc.req0_ready) grants.push_back(1'b0);
            if (ifc.req1_valid && ifc.req1_ready) grants.push_back(1'b1);
            if (ifc.rsp0_valid && ifc.rsp1_valid) begin
                chk("both_rsp_valid", 64'd1, 64'd0);
            end
            if ((ifc.rsp0_valid && ifc.rsp0_ready) ||
                (ifc.rsp1_valid && ifc.rsp1_ready)) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (ifc.rsp1_valid)
                        chk("rsp1", {30'd0, 1'b1, ifc.rsp1_result,
                                     ifc.rsp1_ovf, ifc.rsp1_err},
                            {30'd0, e.idx, e.res, e.ovf, e.err});
                    else
                        chk("rsp0", {30'd0, 1'b0, ifc.rsp0_result,
                                     ifc.rsp0_ovf, ifc.rsp0_err},
                            {30'd0, e.idx, e.res, e.ovf, e.err});
                end
            end
        end
        p0 = ifc.rsp0_valid;
        p1 = ifc.rsp1_valid;
    end

    task automatic do_req(input bit idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res,
                          input bit ovf, input bit err, input bit push,
                          output int acc);
        int   n;
        bit   ok;
        exp_t e;
        @(posedge clk);
        #1;
        if (idx) begin
            ifc.req1_valid = 1'b1; ifc.req1_a = a; ifc.req1_b = b;
        end else begin
            ifc.req0_valid = 1'b1; ifc.req0_a = a; ifc.req0_b = b;
        end
        n   = 0;
        ok  = 0;
        acc = 0;
        while (!ok && n < 400) begin
            @(negedge clk);
            n++;
            ok = idx ? ifc.req1_ready : ifc.req0_ready;
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            acc   = cyc;
            e.idx = idx;
            e.res = res;
            e.ovf = ovf;
            e.err = err;
            if (push) q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (idx) ifc.req1_valid = 1'b0;
        else     ifc.req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
    endtask

    // Global bound so a stuck run still ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1);
    end

    initial begin
        int acc;
        int s0;
        n_reset        = 1'b0;
        ifc.req0_valid = 1'b0; ifc.req0_a = '0; ifc.req0_b = '0;
        ifc.req1_valid = 1'b0; ifc.req1_a = '0; ifc.req1_b = '0;
        ifc.rsp0_ready = 1'b1;
        ifc.rsp1_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_outs",
            {29'd0, done_count, busy, last_grant, ifc.mul_start},
            64'd0);
        chk("reset_rsp",
            {ifc.rsp0_valid, ifc.rsp1_valid, ifc.req0_ready,
             ifc.req1_ready, ifc.rsp0_result, ifc.mul_a},
            64'd0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;

        // Basic multiply, k=4.
        core_k = 4;
        do_req(0, 32'h5, 32'h2, 32'h0000000A, 0, 0, 1, acc);
        drain();
        chk("basic_latency", 64'(rise0 - acc), 64'd6);
        chk("basic_starts", 64'(starts), 64'd1);
        chk("basic_count", 64'(done_count), 64'd1);

        // Zero operand then recovery on requester 1.
        core_k = 2;
        do_req(1, 32'h0, 32'h1, 32'h0, 0, 0, 1, acc);
        drain();
        do_req(1, 32'h2, 32'h3, 32'h6, 0, 0, 1, acc);
        drain();
        chk("zero_count", 64'(done_count), 64'd3);
        chk("zero_last_grant", 64'(last_grant), 64'd1);

        // Overflow.
        do_req(0, 32'h00FFFFFF, 32'h00FFFFFF, 32'hFE000001, 1, 0, 1, acc);
        drain();
        chk("ovf_count", 64'(done_count), 64'd4);

        // Range errors, both operand positions.
        s0 = starts;
        do_req(0, 32'h0FFFFFF1, 32'h5, 32'h0, 0, 1, 1, acc);
        drain();
        chk("range_a_latency", 64'(rise0 - acc), 64'd1);
        do_req(1, 32'h5, 32'h0FFFFFF1, 32'h0, 0, 1, 1, acc);
        drain();
        chk("range_b_latency", 64'(rise1 - acc), 64'd1);
        chk("range_starts", 64'(starts - s0), 64'd0);
        chk("range_count", 64'(done_count), 64'd4);

        // Contention from reset, first response stalled 5 cycles.
        do_reset();
        grants.delete();
        ifc.rsp0_ready = 1'b0;
        ifc.rsp1_ready = 1'b0;
        fork
            begin
                int a0;
                do_req(0, 32'h3, 32'h4, 32'h0000000C, 0, 0, 1, a0);
                do_req(0, 32'h7, 32'h8, 32'h00000038, 0, 0, 1, a0);
            end
            begin
                int a1;
                do_req(1, 32'h10, 32'h10, 32'h00000100, 0, 0, 1, a1);
                do_req(1, 32'h1000, 32'h1000, 32'h01000000, 0, 0, 1, a1);
            end
            begin
                int n;
                n = 0;
                while (!ifc.rsp0_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 5; i++) begin
                    chk("stall_hold",
                        {28'd0, ifc.rsp0_valid, ifc.rsp1_valid,
                         ifc.rsp0_result, ifc.rsp0_ovf, ifc.rsp0_err},
                        {28'd0, 1'b1, 1'b0, 32'h0000000C, 1'b0, 1'b0});
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                ifc.rsp0_ready = 1'b1;
                ifc.rsp1_ready = 1'b1;
            end
        join
        drain();
        chk("grant_count", 64'(grants.size()), 64'd4);
        if (grants.size() == 4) begin
            chk("grant_order",
                {60'd0, grants[0], grants[1], grants[2], grants[3]},
                64'b0101);
        end
        chk("cont_count", 64'(done_count), 64'd4);
        chk("cont_last_grant", 64'(last_grant), 64'd1);

        // Timeout with a core that never answers.
        core_k = 0;
        do_req(0, 32'h9, 32'h9, 32'h0, 0, 1, 1, acc);
        drain();
        chk("timeout_latency", 64'(rise0 - start_cyc), 64'(TIMEOUT + 1));
        chk("timeout_count", 64'(done_count), 64'd4);

        // Stray done in IDLE is ignored.
        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_ignored",
            {29'd0, done_count, busy, ifc.rsp0_valid, ifc.rsp1_valid},
            {29'd0, 32'd4, 3'b000});

        // Reset during WAIT.
        do_req(1, 32'h4, 32'h4, 32'h10, 0, 0, 0, acc);
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        n_reset = 1'b0;
        #1;
        chk("midreset_outs",
            {29'd0, done_count, busy, last_grant, ifc.mul_start},
            64'd0);
        chk("midreset_rsp",
            {ifc.rsp0_valid, ifc.rsp1_valid, ifc.req0_ready,
             ifc.req1_ready, ifc.rsp1_result, ifc.mul_a},
            64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        n_reset = 1'b1;

        // Recovery after reset.
        core_k = 1;
        do_req(0, 32'h2, 32'h3, 32'h6, 0, 0, 1, acc);
        drain();
        chk("post_reset_count", 64'(done_count), 64'd1);
        chk("post_reset_grant", 64'(last_grant), 64'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
